// File: rtl/scan_sequencer.sv
// rtl/scan_sequencer.sv - time-multiplexed channel scanner feeding a 3-to-8 decoder
//
// Steps a 3-bit select through the channels enabled in mask. Each channel is
// shown (sel_en=1) for DWELL_CYC cycles, then sel_en is held low for BLANK_CYC
// cycles. The cycle in which sel changes is always one of those low cycles, so
// the decoder never sees a select change while it is enabled.
//
// Parameters:
//   DWELL_CYC   cycles sel_en is high per channel (>=1)
//   BLANK_CYC   cycles sel_en is low between channels (>=0)
//
// Ports:
//   clk         system clock, rising edge
//   rst_n       asynchronous active-low reset
//   run         1 = scanning enabled
//   mask        channel enable mask, bit i enables channel i
//   sel         channel index (decoder in)
//   sel_en      drive enable (decoder en)
//   step_pulse  1-cycle pulse in the cycle sel takes a new value
//   frame_done  1-cycle pulse when the scan wraps back to the first channel
//
// Build option:
//   SCAN_PINGPONG_EN  when defined, scan bounces lowest->highest->lowest set
//                     bit and frame_done marks the down-to-up turn; when
//                     undefined, ascending circular scan with no direction bit.

module scan_sequencer #(
    parameter int DWELL_CYC = 100000,
    parameter int BLANK_CYC = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       run,
    input  logic [7:0] mask,
    output logic [2:0] sel,
    output logic       sel_en,
    output logic       step_pulse,
    output logic       frame_done
);

    localparam int MAX_CYC = (DWELL_CYC > BLANK_CYC) ? DWELL_CYC : BLANK_CYC;
    localparam int CNT_W   = (MAX_CYC < 1) ? 1 : $clog2(MAX_CYC + 1);

    // In SHOW, cnt=0 is the cycle in which sel has just changed (sel_en still
    // low); cnt=1..DWELL_CYC are the enabled cycles. That first cycle also
    // counts as the final blank cycle, so the BLANK state only has to cover
    // the remaining BLANK_CYC-1 cycles. With BLANK_CYC of 0 or 1 the scan goes
    // straight from the last enabled cycle to the next advance.
    localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(DWELL_CYC);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'((BLANK_CYC >= 2) ? BLANK_CYC - 2 : 0);
    localparam bit               HAS_BLANK  = (BLANK_CYC >= 2);

    typedef enum logic [1:0] {
        IDLE,
        SHOW,
        BLANK
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;

    logic       active;
    logic       adv_now;
    logic [2:0] adv_sel;
    logic       adv_fd;

    function automatic logic [2:0] lowest_set(input logic [7:0] m);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (m[i]) begin
                idx = 3'(i);
            end
        end
        return idx;
    endfunction

    assign active = run && (mask != 8'h00);

    // An advance happens on the edge that ends the last low cycle before the
    // next channel; run=0 or mask=0 in that cycle suppresses it entirely.
    assign adv_now = active &&
                     (((state == SHOW) && (cnt == SHOW_LAST) && !HAS_BLANK) ||
                      ((state == BLANK) && (cnt == BLANK_LAST)));

`ifdef SCAN_PINGPONG_EN
    logic       dir_up;
    logic       adv_dir_up;
    logic [3:0] above;
    logic [3:0] below;

    // {found, index} of the closest set bit strictly above cur
    function automatic logic [3:0] nearest_above(input logic [7:0] m, input logic [2:0] cur);
        logic [3:0] r;
        r = 4'd0;
        for (int i = 7; i >= 0; i--) begin
            if (m[i] && (3'(i) > cur)) begin
                r = {1'b1, 3'(i)};
            end
        end
        return r;
    endfunction

    // {found, index} of the closest set bit strictly below cur
    function automatic logic [3:0] nearest_below(input logic [7:0] m, input logic [2:0] cur);
        logic [3:0] r;
        r = 4'd0;
        for (int i = 0; i < 8; i++) begin
            if (m[i] && (3'(i) < cur)) begin
                r = {1'b1, 3'(i)};
            end
        end
        return r;
    endfunction

    always_comb begin
        above      = nearest_above(mask, sel);
        below      = nearest_below(mask, sel);
        // No other set bit in either direction: stay put, count a frame.
        adv_sel    = sel;
        adv_fd     = 1'b1;
        adv_dir_up = 1'b1;
        if (dir_up) begin
            if (above[3]) begin
                adv_sel    = above[2:0];
                adv_fd     = 1'b0;
                adv_dir_up = 1'b1;
            end else if (below[3]) begin
                adv_sel    = below[2:0];
                adv_fd     = 1'b0;
                adv_dir_up = 1'b0;
            end
        end else begin
            if (below[3]) begin
                adv_sel    = below[2:0];
                adv_fd     = 1'b0;
                adv_dir_up = 1'b0;
            end else if (above[3]) begin
                adv_sel    = above[2:0];
                adv_fd     = 1'b1;
                adv_dir_up = 1'b1;
            end
        end
    end
`else
    // Next set bit strictly after cur, searching circularly; returns cur
    // itself when it is the only set bit.
    function automatic logic [2:0] next_circular(input logic [7:0] m, input logic [2:0] cur);
        logic [2:0] idx;
        logic [2:0] cand;
        logic       found;
        idx   = cur;
        found = 1'b0;
        for (int i = 1; i < 8; i++) begin
            cand = cur + 3'(i);
            if (!found && m[cand]) begin
                idx   = cand;
                found = 1'b1;
            end
        end
        return idx;
    endfunction

    always_comb begin
        adv_sel = next_circular(mask, sel);
        adv_fd  = (adv_sel <= sel);
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            sel        <= 3'd0;
            sel_en     <= 1'b0;
            step_pulse <= 1'b0;
            frame_done <= 1'b0;
`ifdef SCAN_PINGPONG_EN
            dir_up     <= 1'b1;
`endif
        end else begin
            step_pulse <= 1'b0;
            frame_done <= 1'b0;

            case (state)
                IDLE: begin
                    sel_en <= 1'b0;
                    cnt    <= '0;
                    if (active) begin
                        // A restart always begins at the lowest set bit.
                        sel        <= lowest_set(mask);
                        step_pulse <= 1'b1;
                        state      <= SHOW;
`ifdef SCAN_PINGPONG_EN
                        dir_up     <= 1'b1;
`endif
                    end
                end

                SHOW: begin
                    if (!active) begin
                        state  <= IDLE;
                        sel_en <= 1'b0;
                        cnt    <= '0;
                    end else if (cnt == SHOW_LAST) begin
                        sel_en <= 1'b0;
                        cnt    <= '0;
                        if (HAS_BLANK) begin
                            state <= BLANK;
                        end
                    end else begin
                        sel_en <= 1'b1;
                        cnt    <= cnt + 1'b1;
                    end
                end

                BLANK: begin
                    sel_en <= 1'b0;
                    if (!active) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                default: begin
                    state  <= IDLE;
                    sel_en <= 1'b0;
                    cnt    <= '0;
                end
            endcase

            // Advance overrides the per-state updates above: new channel,
            // pulses, and restart of the SHOW count with sel_en held low.
            if (adv_now) begin
                sel        <= adv_sel;
                step_pulse <= 1'b1;
                frame_done <= adv_fd;
                state      <= SHOW;
                cnt        <= '0;
                sel_en     <= 1'b0;
`ifdef SCAN_PINGPONG_EN
                dir_up     <= adv_dir_up;
`endif
            end
        end
    end

endmodule

// File: tb/tb_scan_sequencer.sv
// tb/tb_scan_sequencer.sv - randomized self-checking bench for scan_sequencer

module tb_scan_sequencer;

    localparam int DW = 4;
    localparam int BL = 2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       run_a, run_b;
    logic [7:0] mask_a, mask_b;
    logic [2:0] sel_a, sel_b;
    logic       en_a, en_b, stp_a, stp_b, fd_a, fd_b;

    always #5 clk = ~clk;

    scan_sequencer #(.DWELL_CYC(DW), .BLANK_CYC(BL)) dut_a (
        .clk(clk), .rst_n(rst_n), .run(run_a), .mask(mask_a),
        .sel(sel_a), .sel_en(en_a), .step_pulse(stp_a), .frame_done(fd_a)
    );

    scan_sequencer #(.DWELL_CYC(DW), .BLANK_CYC(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .run(run_b), .mask(mask_b),
        .sel(sel_b), .sel_en(en_b), .step_pulse(stp_b), .frame_done(fd_b)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Reference model: position within a scan period of DW + max(BLANK,1)
    // cycles, position 0 being the step cycle and 1..DW the enabled cycles.
    int   per [2];
    bit   m_act [2];
    int   m_pos [2];
    int   m_sel [2];
    bit   m_up  [2];
    bit   m_en  [2];
    bit   m_stp [2];
    bit   m_fd  [2];

    int qa_sel[$], qa_fd[$], qa_cyc[$];
    int qb_sel[$], qb_fd[$], qb_cyc[$];

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_act[k] = 0; m_pos[k] = 0; m_sel[k] = 0; m_up[k] = 1;
            m_en[k] = 0; m_stp[k] = 0; m_fd[k] = 0;
        end
    endtask

    task automatic model_adv(input int k, input logic [7:0] m);
        int old, above, below, lo;
        old = m_sel[k]; above = -1; below = -1; lo = -1;
        for (int i = 0; i < 8; i++) begin
            if (m[i]) begin
                if (lo < 0) lo = i;
                if (i > old && above < 0) above = i;
                if (i < old) below = i;
            end
        end
`ifdef SCAN_PINGPONG_EN
        m_fd[k] = 0;
        if (m_up[k]) begin
            if (above >= 0) m_sel[k] = above;
            else if (below >= 0) begin m_sel[k] = below; m_up[k] = 0; end
            else begin m_fd[k] = 1; m_up[k] = 1; end
        end else begin
            if (below >= 0) m_sel[k] = below;
            else if (above >= 0) begin m_sel[k] = above; m_up[k] = 1; m_fd[k] = 1; end
            else begin m_fd[k] = 1; m_up[k] = 1; end
        end
`else
        m_sel[k] = (above >= 0) ? above : lo;
        m_fd[k]  = (m_sel[k] <= old);
`endif
    endtask

    task automatic model_edge(input int k, input logic r, input logic [7:0] m);
        m_stp[k] = 0;
        m_fd[k]  = 0;
        if (!m_act[k]) begin
            m_en[k] = 0;
            if (r && m != 8'h00) begin
                m_act[k] = 1; m_pos[k] = 0; m_up[k] = 1; m_stp[k] = 1;
                for (int i = 7; i >= 0; i--) if (m[i]) m_sel[k] = i;
            end
        end else if (!r || m == 8'h00) begin
            m_act[k] = 0; m_en[k] = 0;
        end else begin
            m_pos[k]++;
            if (m_pos[k] == per[k]) begin
                m_pos[k] = 0;
                m_stp[k] = 1;
                model_adv(k, m);
            end
            m_en[k] = (m_pos[k] >= 1 && m_pos[k] <= DW);
        end
    endtask

    // One clock: advance the model with the inputs present at the edge,
    // then compare both DUTs against it and log step events.
    task automatic tick();
        @(posedge clk);
        model_edge(0, run_a, mask_a);
        model_edge(1, run_b, mask_b);
        #1;
        cyc++;
        total += 8;
        if (sel_a !== 3'(m_sel[0])) begin bad++; $display("FAIL a.sel cyc=%0d got=%0d exp=%0d", cyc, sel_a, m_sel[0]); end
        if (en_a !== m_en[0])       begin bad++; $display("FAIL a.sel_en cyc=%0d got=%0b exp=%0b", cyc, en_a, m_en[0]); end
        if (stp_a !== m_stp[0])     begin bad++; $display("FAIL a.step cyc=%0d got=%0b exp=%0b", cyc, stp_a, m_stp[0]); end
        if (fd_a !== m_fd[0])       begin bad++; $display("FAIL a.frame cyc=%0d got=%0b exp=%0b", cyc, fd_a, m_fd[0]); end
        if (sel_b !== 3'(m_sel[1])) begin bad++; $display("FAIL b.sel cyc=%0d got=%0d exp=%0d", cyc, sel_b, m_sel[1]); end
        if (en_b !== m_en[1])       begin bad++; $display("FAIL b.sel_en cyc=%0d got=%0b exp=%0b", cyc, en_b, m_en[1]); end
        if (stp_b !== m_stp[1])     begin bad++; $display("FAIL b.step cyc=%0d got=%0b exp=%0b", cyc, stp_b, m_stp[1]); end
        if (fd_b !== m_fd[1])       begin bad++; $display("FAIL b.frame cyc=%0d got=%0b exp=%0b", cyc, fd_b, m_fd[1]); end
        if (stp_a === 1'b1) begin qa_sel.push_back(int'(sel_a)); qa_fd.push_back(int'(fd_a)); qa_cyc.push_back(cyc); end
        if (stp_b === 1'b1) begin qb_sel.push_back(int'(sel_b)); qb_fd.push_back(int'(fd_b)); qb_cyc.push_back(cyc); end
    endtask

    task automatic go_idle();
        run_a = 0; run_b = 0;
        repeat (2) tick();
        qa_sel.delete(); qa_fd.delete(); qa_cyc.delete();
        qb_sel.delete(); qb_fd.delete(); qb_cyc.delete();
    endtask

    task automatic test_reset();
        rst_n = 0; run_a = 0; run_b = 0; mask_a = 0; mask_b = 0;
        model_reset();
        @(posedge clk); #1;
        total += 4;
        if (sel_a !== 3'd0) begin bad++; $display("FAIL rst.sel got=%0d exp=0", sel_a); end
        if (en_a !== 1'b0)  begin bad++; $display("FAIL rst.sel_en got=%0b exp=0", en_a); end
        if (stp_a !== 1'b0) begin bad++; $display("FAIL rst.step got=%0b exp=0", stp_a); end
        if (fd_a !== 1'b0)  begin bad++; $display("FAIL rst.frame got=%0b exp=0", fd_a); end
        @(negedge clk); rst_n = 1;
        // async reset in the middle of a dwell on channel 5
        mask_a = 8'h20; run_a = 1;
        repeat (3) tick();
        @(posedge clk); #3;
        rst_n = 0;
        #1;
        total += 4;
        if (sel_a !== 3'd0) begin bad++; $display("FAIL async_rst.sel got=%0d exp=0", sel_a); end
        if (en_a !== 1'b0)  begin bad++; $display("FAIL async_rst.sel_en got=%0b exp=0", en_a); end
        if (stp_a !== 1'b0) begin bad++; $display("FAIL async_rst.step got=%0b exp=0", stp_a); end
        if (fd_a !== 1'b0)  begin bad++; $display("FAIL async_rst.frame got=%0b exp=0", fd_a); end
        model_reset();
        run_a = 0; mask_a = 0;
        @(negedge clk); rst_n = 1;
        go_idle();
    endtask

    task automatic test_full_mask();
        int c;
        mask_a = 8'hFF; run_a = 1;
        c = 0;
        while (qa_sel.size() < 9 && c < 100) begin tick(); c++; end
        total++;
        if (qa_sel.size() != 9) begin bad++; $display("FAIL full.steps got=%0d exp=9", qa_sel.size()); end
        for (int i = 0; i < qa_sel.size() && i < 9; i++) begin
            total += 2;
            if (qa_sel[i] != i % 8) begin bad++; $display("FAIL full.sel[%0d] got=%0d exp=%0d", i, qa_sel[i], i % 8); end
            if (qa_fd[i] != ((i == 8) ? 1 : 0)) begin bad++; $display("FAIL full.frame[%0d] got=%0d exp=%0d", i, qa_fd[i], (i == 8) ? 1 : 0); end
            if (i > 0) begin
                total++;
                if (qa_cyc[i] - qa_cyc[i-1] != DW + BL) begin bad++; $display("FAIL full.period[%0d] got=%0d exp=%0d", i, qa_cyc[i] - qa_cyc[i-1], DW + BL); end
            end
        end
        go_idle();
    endtask

    task automatic test_sparse_mask();
        int c;
        int exp_sel [7] = '{2, 5, 7, 2, 5, 7, 0};
        int exp_fd  [7] = '{0, 0, 0, 1, 0, 0, 1};
        mask_a = 8'b1010_0100; run_a = 1;
        c = 0;
        while (qa_sel.size() < 6 && c < 100) begin tick(); c++; end
        // channel 7 was just selected; masking it off must not cut its dwell
        mask_a = 8'h01;
        while (qa_sel.size() < 7 && c < 100) begin tick(); c++; end
        total++;
        if (qa_sel.size() != 7) begin bad++; $display("FAIL sparse.steps got=%0d exp=7", qa_sel.size()); end
        for (int i = 0; i < qa_sel.size() && i < 7; i++) begin
            total += 2;
            if (qa_sel[i] != exp_sel[i]) begin bad++; $display("FAIL sparse.sel[%0d] got=%0d exp=%0d", i, qa_sel[i], exp_sel[i]); end
            if (qa_fd[i] != exp_fd[i])   begin bad++; $display("FAIL sparse.frame[%0d] got=%0d exp=%0d", i, qa_fd[i], exp_fd[i]); end
        end
        go_idle();
    endtask

    task automatic test_run_drop();
        int c;
        mask_a = 8'hFF; run_a = 1;
        c = 0;
        while (!(qa_sel.size() > 0 && qa_sel[qa_sel.size()-1] == 3) && c < 100) begin tick(); c++; end
        total++;
        if (c >= 100) begin bad++; $display("FAIL drop.reach3 got=timeout exp=sel3"); end
        repeat (DW + BL - 1) tick();   // now in the last blank cycle of channel 3
        run_a = 0;
        tick();
        total += 3;
        if (sel_a !== 3'd3) begin bad++; $display("FAIL drop.sel got=%0d exp=3", sel_a); end
        if (stp_a !== 1'b0) begin bad++; $display("FAIL drop.step got=%0b exp=0", stp_a); end
        if (en_a !== 1'b0)  begin bad++; $display("FAIL drop.sel_en got=%0b exp=0", en_a); end
        repeat (3) tick();
        total++;
        if (sel_a !== 3'd3) begin bad++; $display("FAIL drop.hold got=%0d exp=3", sel_a); end
        run_a = 1;
        tick();
        total += 2;
        if (sel_a !== 3'd0) begin bad++; $display("FAIL drop.restart_sel got=%0d exp=0", sel_a); end
        if (stp_a !== 1'b1) begin bad++; $display("FAIL drop.restart_step got=%0b exp=1", stp_a); end
        go_idle();
    endtask

    task automatic test_blank_zero();
        int c;
        int exp_sel [4] = '{0, 4, 0, 4};
`ifdef SCAN_PINGPONG_EN
        int exp_fd  [4] = '{0, 0, 0, 1};
`else
        int exp_fd  [4] = '{0, 0, 1, 0};
`endif
        mask_b = 8'h11; run_b = 1;
        c = 0;
        while (qb_sel.size() < 4 && c < 100) begin tick(); c++; end
        total++;
        if (qb_sel.size() != 4) begin bad++; $display("FAIL blank0.steps got=%0d exp=4", qb_sel.size()); end
        for (int i = 0; i < qb_sel.size() && i < 4; i++) begin
            total += 2;
            if (qb_sel[i] != exp_sel[i]) begin bad++; $display("FAIL blank0.sel[%0d] got=%0d exp=%0d", i, qb_sel[i], exp_sel[i]); end
            if (qb_fd[i] != exp_fd[i])   begin bad++; $display("FAIL blank0.frame[%0d] got=%0d exp=%0d", i, qb_fd[i], exp_fd[i]); end
            if (i > 0) begin
                total++;
                if (qb_cyc[i] - qb_cyc[i-1] != DW + 1) begin bad++; $display("FAIL blank0.period[%0d] got=%0d exp=%0d", i, qb_cyc[i] - qb_cyc[i-1], DW + 1); end
            end
        end
        go_idle();
    endtask

`ifdef SCAN_PINGPONG_EN
    task automatic test_pingpong();
        int c;
        int exp_sel [6] = '{0, 4, 7, 4, 0, 4};
        int exp_fd  [6] = '{0, 0, 0, 0, 0, 1};
        mask_a = 8'b1001_0001; run_a = 1;
        c = 0;
        while (qa_sel.size() < 6 && c < 100) begin tick(); c++; end
        total++;
        if (qa_sel.size() != 6) begin bad++; $display("FAIL pp.steps got=%0d exp=6", qa_sel.size()); end
        for (int i = 0; i < qa_sel.size() && i < 6; i++) begin
            total += 2;
            if (qa_sel[i] != exp_sel[i]) begin bad++; $display("FAIL pp.sel[%0d] got=%0d exp=%0d", i, qa_sel[i], exp_sel[i]); end
            if (qa_fd[i] != exp_fd[i])   begin bad++; $display("FAIL pp.frame[%0d] got=%0d exp=%0d", i, qa_fd[i], exp_fd[i]); end
        end
        go_idle();
    endtask
`endif

    function automatic logic [7:0] rand_mask();
        int pick;
        pick = $urandom_range(0, 9);
        if (pick == 0) return 8'h00;
        if (pick <= 2) return 8'(1 << $urandom_range(0, 7));
        return 8'($urandom_range(0, 255));
    endfunction

    task automatic test_random();
        mask_a = rand_mask(); mask_b = rand_mask();
        run_a = 1; run_b = 1;
        for (int i = 0; i < 600; i++) begin
            tick();
            if ($urandom_range(0, 14) == 0) mask_a = rand_mask();
            if ($urandom_range(0, 14) == 0) mask_b = rand_mask();
            if ($urandom_range(0, 39) == 0) run_a = ~run_a;
            if ($urandom_range(0, 39) == 0) run_b = ~run_b;
        end
        go_idle();
    endtask

    initial begin
        per[0] = DW + ((BL > 0) ? BL : 1);
        per[1] = DW + 1;
        test_reset();
`ifdef SCAN_PINGPONG_EN
        test_pingpong();
`else
        test_full_mask();
        test_sparse_mask();
`endif
        test_run_drop();
        test_blank_zero();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
